// File: rtl/dcache_miss_controller_if.sv
// Main-memory port of the data-cache miss controller: one word per req/ack handshake.
interface dcache_miss_controller_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  MM_REQ;
    logic                  MM_WE;
    logic [ADDR_WIDTH-1:0] MM_ADDR;
    logic                  MM_ACK;

    modport master (output MM_REQ, output MM_WE, output MM_ADDR, input MM_ACK);
    modport slave  (input MM_REQ, input MM_WE, input MM_ADDR, output MM_ACK);
endinterface

// File: rtl/dcache_miss_controller.sv
// Data-cache miss sequencer: stalls the pipeline, writes back a dirty victim line,
// refills the missing line word by word, then commits the tag.
module dcache_miss_controller #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned WORD_IDX_BITS  = 2,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     MEM_READ,
    input  logic                     MEM_WRITE,
    input  logic                     HIT,
    input  logic                     DIRTY,
    input  logic [ADDR_WIDTH-1:0]    ADDR,
    input  logic [ADDR_WIDTH-1:0]    VICTIM_ADDR,
    dcache_miss_controller_if.master mm,
    output logic                     STALL,
    output logic [WORD_IDX_BITS-1:0] LINE_WORD,
    output logic                     CACHE_FILL_WE,
    output logic                     TAG_UPDATE,
    output logic [CNT_WIDTH-1:0]     MISS_COUNT
);

    localparam int unsigned OffBits = WORD_IDX_BITS + 2;
    localparam logic [ADDR_WIDTH-1:0] OffMask = ADDR_WIDTH'((64'd1 << OffBits) - 64'd1);
    localparam logic [WORD_IDX_BITS-1:0] LastWord = WORD_IDX_BITS'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {StIdle, StWb, StFill, StCommit} state_e;

    state_e                  state_q;
    logic [WORD_IDX_BITS-1:0] word_q;
    logic [ADDR_WIDTH-1:0]   miss_base_q;
    logic [ADDR_WIDTH-1:0]   victim_base_q;
    logic [CNT_WIDTH-1:0]    miss_count_q;

    logic                  in_idle;
    logic                  miss;
    logic [ADDR_WIDTH-1:0] word_off;
    logic                  mm_req;
    logic                  mm_we;
    logic [ADDR_WIDTH-1:0] mm_addr;

    assign in_idle  = (state_q == StIdle);
    assign miss     = in_idle & (MEM_READ | MEM_WRITE) & ~HIT;
    assign word_off = ADDR_WIDTH'({word_q, 2'b00});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            word_q        <= '0;
            miss_base_q   <= '0;
            victim_base_q <= '0;
            miss_count_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (miss) begin
                        miss_base_q   <= ADDR & ~OffMask;
                        victim_base_q <= VICTIM_ADDR & ~OffMask;
                        word_q        <= '0;
                        if (miss_count_q != '1) miss_count_q <= miss_count_q + CNT_WIDTH'(1);
                        state_q <= DIRTY ? StWb : StFill;
                    end
                end
                StWb: begin
                    if (mm.MM_ACK) begin
                        // Counter wraps to 0 on the last word, ready for the refill.
                        word_q <= word_q + WORD_IDX_BITS'(1);
                        if (word_q == LastWord) state_q <= StFill;
                    end
                end
                StFill: begin
                    if (mm.MM_ACK) begin
                        word_q <= word_q + WORD_IDX_BITS'(1);
                        if (word_q == LastWord) state_q <= StCommit;
                    end
                end
                StCommit: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        mm_req        = 1'b0;
        mm_we         = 1'b0;
        mm_addr       = '0;
        LINE_WORD     = '0;
        CACHE_FILL_WE = 1'b0;
        TAG_UPDATE    = 1'b0;
        unique case (state_q)
            StWb: begin
                mm_req    = 1'b1;
                mm_we     = 1'b1;
                mm_addr   = victim_base_q + word_off;
                LINE_WORD = word_q;
            end
            StFill: begin
                mm_req        = 1'b1;
                mm_addr       = miss_base_q + word_off;
                LINE_WORD     = word_q;
                CACHE_FILL_WE = mm.MM_ACK;
            end
            StCommit: TAG_UPDATE = 1'b1;
            default: ;
        endcase
    end

    assign STALL      = miss | ~in_idle;
    assign MISS_COUNT = miss_count_q;
    assign mm.MM_REQ  = mm_req;
    assign mm.MM_WE   = mm_we;
    assign mm.MM_ADDR = mm_addr;

endmodule
